integrate_dump: RTL and testbench

- Decimating integrate-and-dump stage directly downstream of the two-tap sum filter.
- Accumulates N consecutive enabled signed samples, scales the sum by a programmable right shift and saturates it to the output width.
- Emits one result per N input samples with a single-cycle valid strobe.
- Feeds the slow-rate logging and feedback path.

---
 rtl/integrate_dump_if.sv | 29 ++
 rtl/integrate_dump.sv | 123 ++++++++++++
 tb/tb_integrate_dump.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/integrate_dump_if.sv
// Sample/result bundle between the sum filter, the integrate-and-dump stage and
// the slow-rate consumer. The master drives samples and controls; the slave returns results.
interface integrate_dump_if #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 32,
    parameter int CNT_WIDTH = 16
);
    logic signed [WIDTH-1:0]     data_i;
    logic                        en_i;
    logic                        clear_i;
    logic [CNT_WIDTH-1:0]        ratio_i;
    logic [4:0]                  shift_i;

    logic signed [WIDTH-1:0]     data_o;
    logic signed [ACC_WIDTH-1:0] sum_o;
    logic                        valid_o;
    logic                        sat_o;
    logic                        overflow_o;

    modport master (
        output data_i, en_i, clear_i, ratio_i, shift_i,
        input  data_o, sum_o, valid_o, sat_o, overflow_o
    );

    modport slave (
        input  data_i, en_i, clear_i, ratio_i, shift_i,
        output data_o, sum_o, valid_o, sat_o, overflow_o
    );
endinterface

// File: rtl/integrate_dump.sv
// Decimating integrate-and-dump: sums N enabled signed samples, then emits the raw
// sum plus a shifted, saturated copy with a one-cycle valid strobe.
module integrate_dump #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    integrate_dump_if.slave  bus
);

    localparam logic signed [WIDTH-1:0] OUT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] OUT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] acc_reg, acc_next;
    logic [CNT_WIDTH-1:0]        cnt_reg, cnt_next;
    logic [CNT_WIDTH-1:0]        ratio_q_reg, ratio_q_next;
    logic signed [WIDTH-1:0]     data_reg, data_next;
    logic signed [ACC_WIDTH-1:0] sum_reg, sum_next;
    logic                        valid_reg, valid_next;
    logic                        sat_reg, sat_next;
    logic                        ovf_reg, ovf_next;

    logic [CNT_WIDTH-1:0]        ratio_in;
    logic [CNT_WIDTH-1:0]        ratio_eff;
    logic signed [ACC_WIDTH-1:0] sample_ext;
    logic signed [ACC_WIDTH-1:0] sum_nxt;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic [ACC_WIDTH-WIDTH:0]    upper_bits;
    logic                        in_range;
    logic signed [WIDTH-1:0]     clamped;
    logic                        add_ovf;
    logic                        last_sample;

    generate
        if (ACC_WIDTH > WIDTH) begin : g_sext
            assign sample_ext = {{(ACC_WIDTH-WIDTH){bus.data_i[WIDTH-1]}}, bus.data_i};
        end else begin : g_same
            assign sample_ext = bus.data_i;
        end
    endgenerate

    // A ratio of 0 behaves as 1; the live input only matters on the first sample of a frame.
    assign ratio_in    = (bus.ratio_i == '0) ? CNT_WIDTH'(1) : bus.ratio_i;
    assign ratio_eff   = (cnt_reg == '0) ? ratio_in : ratio_q_reg;
    assign last_sample = (cnt_reg == ratio_eff - CNT_WIDTH'(1));

    assign sum_nxt = acc_reg + sample_ext;
    assign add_ovf = (acc_reg[ACC_WIDTH-1] == sample_ext[ACC_WIDTH-1]) &&
                     (sum_nxt[ACC_WIDTH-1] != acc_reg[ACC_WIDTH-1]);

    // The scaled value fits the output only if every bit above the output sign bit matches it.
    assign shifted    = sum_nxt >>> bus.shift_i;
    assign upper_bits = shifted[ACC_WIDTH-1:WIDTH-1];
    assign in_range   = (&upper_bits) | ~(|upper_bits);
    assign clamped    = in_range ? shifted[WIDTH-1:0]
                                 : (shifted[ACC_WIDTH-1] ? OUT_MIN : OUT_MAX);

    always_comb begin
        acc_next     = acc_reg;
        cnt_next     = cnt_reg;
        ratio_q_next = ratio_q_reg;
        data_next    = data_reg;
        sum_next     = sum_reg;
        valid_next   = 1'b0;
        sat_next     = sat_reg;
        ovf_next     = ovf_reg;

        if (bus.clear_i) begin
            acc_next = '0;
            cnt_next = '0;
            ovf_next = 1'b0;
        end else if (bus.en_i) begin
            if (add_ovf) begin
                ovf_next = 1'b1;
            end
            if (cnt_reg == '0) begin
                ratio_q_next = ratio_in;
            end
            if (last_sample) begin
                sum_next   = sum_nxt;
                data_next  = clamped;
                sat_next   = ~in_range;
                valid_next = 1'b1;
                acc_next   = '0;
                cnt_next   = '0;
            end else begin
                acc_next = sum_nxt;
                cnt_next = cnt_reg + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_reg     <= '0;
            cnt_reg     <= '0;
            ratio_q_reg <= CNT_WIDTH'(1);
            data_reg    <= '0;
            sum_reg     <= '0;
            valid_reg   <= 1'b0;
            sat_reg     <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            acc_reg     <= acc_next;
            cnt_reg     <= cnt_next;
            ratio_q_reg <= ratio_q_next;
            data_reg    <= data_next;
            sum_reg     <= sum_next;
            valid_reg   <= valid_next;
            sat_reg     <= sat_next;
            ovf_reg     <= ovf_next;
        end
    end

    assign bus.data_o     = data_reg;
    assign bus.sum_o      = sum_reg;
    assign bus.valid_o    = valid_reg;
    assign bus.sat_o      = sat_reg;
    assign bus.overflow_o = ovf_reg;

endmodule

// File: tb/tb_integrate_dump.sv
// Bench for integrate_dump: directed scenarios plus randomized traffic against a
// frame-level reference model (queue of accepted samples per frame).
`timescale 1ns/1ps
module tb_integrate_dump;
    localparam int WIDTH     = 16;
    localparam int ACC_WIDTH = 32;
    localparam int CNT_WIDTH = 16;
    localparam longint ACC_MAX = 64'sd2147483647;
    localparam longint ACC_MIN = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    integrate_dump_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();
    integrate_dump_if #(.WIDTH(WIDTH), .ACC_WIDTH(16), .CNT_WIDTH(CNT_WIDTH)) bus16 ();

    integrate_dump #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus)
    );
    integrate_dump #(.WIDTH(WIDTH), .ACC_WIDTH(16), .CNT_WIDTH(CNT_WIDTH)) dut16 (
        .clk_i(clk), .rst_i(rst), .bus(bus16)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: samples of the current frame and the expected output registers.
    int     frame_q[$];
    int     frame_ratio;
    bit     e_valid, e_sat, e_ovf;
    longint e_sum;
    int     e_data;

    function automatic longint wrap_acc(input longint v);
        logic signed [31:0] t;
        t = v[31:0];
        return longint'(t);
    endfunction

    function automatic void model_reset();
        frame_q.delete();
        frame_ratio = 1;
        e_valid = 0; e_sat = 0; e_ovf = 0; e_sum = 0; e_data = 0;
    endfunction

    function automatic void model_step(input bit en, input bit clr, input int data,
                                       input int ratio, input int shift);
        longint acc, ideal, sh;
        e_valid = 0;
        if (clr) begin
            frame_q.delete();
            e_ovf = 0;
            return;
        end
        if (!en) return;
        if (frame_q.size() == 0) frame_ratio = (ratio == 0) ? 1 : ratio;
        acc = 0;
        foreach (frame_q[k]) acc = wrap_acc(acc + longint'(frame_q[k]));
        ideal = acc + longint'(data);
        if (ideal > ACC_MAX || ideal < ACC_MIN) e_ovf = 1;
        frame_q.push_back(data);
        if (frame_q.size() == frame_ratio) begin
            e_sum = wrap_acc(ideal);
            sh = e_sum >>> shift;
            if (sh > 32767) begin
                e_data = 32767; e_sat = 1;
            end else if (sh < -32768) begin
                e_data = -32768; e_sat = 1;
            end else begin
                e_data = int'(sh); e_sat = 0;
            end
            e_valid = 1;
            frame_q.delete();
        end
    endfunction

    task automatic step(input bit en, input bit clr, input int data, input int ratio, input int shift);
        bus.en_i    = en;
        bus.clear_i = clr;
        bus.data_i  = WIDTH'(data);
        bus.ratio_i = CNT_WIDTH'(ratio);
        bus.shift_i = 5'(shift);
        @(posedge clk);
        model_step(en, clr, data, ratio, shift);
        #1;
    endtask

    task automatic step16(input bit en, input bit clr, input int data);
        bus16.en_i    = en;
        bus16.clear_i = clr;
        bus16.data_i  = WIDTH'(data);
        bus16.ratio_i = 16'd2;
        bus16.shift_i = 5'd0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (bus.valid_o !== 1'b0 || bus.sat_o !== 1'b0 || bus.overflow_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got valid=%b sat=%b ovf=%b expected 0 0 0",
                     bus.valid_o, bus.sat_o, bus.overflow_o);
        end
        tests_run++;
        if (bus.data_o !== 16'sd0 || bus.sum_o !== 32'sd0) begin
            tests_failed++;
            $display("FAIL reset_data: got data=%0d sum=%0d expected 0 0", bus.data_o, bus.sum_o);
        end
        tests_run++;
        if (bus16.valid_o !== 1'b0 || bus16.overflow_o !== 1'b0 || bus16.sum_o !== 16'sd0) begin
            tests_failed++;
            $display("FAIL reset_dut16: got valid=%b ovf=%b sum=%0d expected 0 0 0",
                     bus16.valid_o, bus16.overflow_o, bus16.sum_o);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        int samples[4] = '{100, 200, 300, 400};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, samples[i], 4, 2);
            tests_run++;
            if (bus.valid_o !== (i == 3)) begin
                tests_failed++;
                $display("FAIL basic_valid[%0d]: got %b expected %b", i, bus.valid_o, (i == 3));
            end
        end
        tests_run++;
        if (bus.sum_o !== 32'sd1000 || bus.data_o !== 16'sd250 || bus.sat_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_result: got sum=%0d data=%0d sat=%b expected 1000 250 0",
                     bus.sum_o, bus.data_o, bus.sat_o);
        end
        step(1'b0, 1'b0, 0, 4, 2);
        tests_run++;
        if (bus.valid_o !== 1'b0 || bus.data_o !== 16'sd250) begin
            tests_failed++;
            $display("FAIL basic_hold: got valid=%b data=%0d expected 0 250", bus.valid_o, bus.data_o);
        end
    endtask

    task automatic test_ratio_one();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, -5, 0, 0);
            tests_run++;
            if (bus.valid_o !== 1'b1 || bus.data_o !== -16'sd5 || bus.sum_o !== -32'sd5) begin
                tests_failed++;
                $display("FAIL ratio_one[%0d]: got valid=%b data=%0d sum=%0d expected 1 -5 -5",
                         i, bus.valid_o, bus.data_o, bus.sum_o);
            end
        end
    endtask

    task automatic test_gaps();
        bit en_pat[6]  = '{1, 0, 0, 1, 0, 1};
        int dat_pat[6] = '{10, 77, -9, 20, 555, 30};
        for (int i = 0; i < 6; i++) begin
            step(en_pat[i], 1'b0, dat_pat[i], (i == 0) ? 3 : 8, 0);
            tests_run++;
            if (bus.valid_o !== (i == 5)) begin
                tests_failed++;
                $display("FAIL gaps_valid[%0d]: got %b expected %b", i, bus.valid_o, (i == 5));
            end
        end
        tests_run++;
        if (bus.sum_o !== 32'sd60 || bus.data_o !== 16'sd60) begin
            tests_failed++;
            $display("FAIL gaps_sum: got sum=%0d data=%0d expected 60 60", bus.sum_o, bus.data_o);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32767, 4, 0);
        tests_run++;
        if (bus.valid_o !== 1'b1 || bus.sum_o !== 32'sd131068 || bus.data_o !== 16'sd32767 ||
            bus.sat_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_pos: got valid=%b sum=%0d data=%0d sat=%b expected 1 131068 32767 1",
                     bus.valid_o, bus.sum_o, bus.data_o, bus.sat_o);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, -32768, 4, 0);
        tests_run++;
        if (bus.valid_o !== 1'b1 || bus.sum_o !== -32'sd131072 || bus.data_o !== -16'sd32768 ||
            bus.sat_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_neg: got valid=%b sum=%0d data=%0d sat=%b expected 1 -131072 -32768 1",
                     bus.valid_o, bus.sum_o, bus.data_o, bus.sat_o);
        end
        // Shift of 31 on a negative sum must give -1 without clamping.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, -3, 4, 31);
        tests_run++;
        if (bus.data_o !== -16'sd1 || bus.sat_o !== 1'b0 || bus.sum_o !== -32'sd12) begin
            tests_failed++;
            $display("FAIL shift_max: got data=%0d sat=%b sum=%0d expected -1 0 -12",
                     bus.data_o, bus.sat_o, bus.sum_o);
        end
    endtask

    task automatic test_clear();
        step(1'b1, 1'b0, 7, 4, 0);
        step(1'b1, 1'b0, 7, 4, 0);
        step(1'b1, 1'b1, 999, 4, 0);
        tests_run++;
        if (bus.valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_cycle: got valid=%b expected 0", bus.valid_o);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1, 4, 0);
            tests_run++;
            if (bus.valid_o !== (i == 3)) begin
                tests_failed++;
                $display("FAIL clear_valid[%0d]: got %b expected %b", i, bus.valid_o, (i == 3));
            end
        end
        tests_run++;
        if (bus.sum_o !== 32'sd4 || bus.overflow_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_result: got sum=%0d ovf=%b expected 4 0", bus.sum_o, bus.overflow_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit en, clr;
            int d, r, s;
            en  = ($urandom_range(0, 9) < 7);
            clr = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 7))
                0:       d = 32767;
                1:       d = -32768;
                default: d = int'($urandom_range(0, 65535)) - 32768;
            endcase
            r = int'($urandom_range(0, 6));
            s = int'($urandom_range(0, 31));
            step(en, clr, d, r, s);
            tests_run++;
            if (bus.valid_o !== e_valid || bus.sum_o !== ACC_WIDTH'(e_sum) ||
                bus.data_o !== WIDTH'(e_data) || bus.sat_o !== e_sat ||
                bus.overflow_o !== e_ovf) begin
                tests_failed++;
                $display("FAIL random[%0d]: got v=%b sum=%0d data=%0d sat=%b ovf=%b expected v=%b sum=%0d data=%0d sat=%b ovf=%b",
                         i, bus.valid_o, bus.sum_o, bus.data_o, bus.sat_o, bus.overflow_o,
                         e_valid, e_sum, e_data, e_sat, e_ovf);
            end
        end
    endtask

    task automatic test_overflow16();
        step16(1'b1, 1'b0, 32767);
        tests_run++;
        if (bus16.overflow_o !== 1'b0 || bus16.valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf16_first: got ovf=%b valid=%b expected 0 0", bus16.overflow_o, bus16.valid_o);
        end
        step16(1'b1, 1'b0, 32767);
        tests_run++;
        if (bus16.overflow_o !== 1'b1 || bus16.valid_o !== 1'b1 || bus16.sum_o !== -16'sd2) begin
            tests_failed++;
            $display("FAIL ovf16_dump: got ovf=%b valid=%b sum=%0d expected 1 1 -2",
                     bus16.overflow_o, bus16.valid_o, bus16.sum_o);
        end
        for (int i = 0; i < 3; i++) step16(1'b1, 1'b0, 1);
        tests_run++;
        if (bus16.overflow_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf16_sticky: got %b expected 1", bus16.overflow_o);
        end
        step16(1'b0, 1'b1, 0);
        tests_run++;
        if (bus16.overflow_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf16_clear: got %b expected 0", bus16.overflow_o);
        end
        // Start a frame, then reset asynchronously between clock edges.
        step16(1'b1, 1'b0, 5);
        step16(1'b1, 1'b0, 3);
        step16(1'b1, 1'b0, 5);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (bus16.valid_o !== 1'b0 || bus16.sum_o !== 16'sd0 || bus16.data_o !== 16'sd0 ||
            bus16.sat_o !== 1'b0 || bus16.overflow_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_async16: got v=%b sum=%0d data=%0d sat=%b ovf=%b expected all 0",
                     bus16.valid_o, bus16.sum_o, bus16.data_o, bus16.sat_o, bus16.overflow_o);
        end
        tests_run++;
        if (bus.valid_o !== 1'b0 || bus.sum_o !== 32'sd0 || bus.data_o !== 16'sd0) begin
            tests_failed++;
            $display("FAIL rst_async32: got v=%b sum=%0d data=%0d expected 0 0 0",
                     bus.valid_o, bus.sum_o, bus.data_o);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        step16(1'b1, 1'b0, 6);
        tests_run++;
        if (bus16.valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_no_pulse: got valid=%b expected 0", bus16.valid_o);
        end
        step16(1'b1, 1'b0, 6);
        tests_run++;
        if (bus16.valid_o !== 1'b1 || bus16.sum_o !== 16'sd12) begin
            tests_failed++;
            $display("FAIL rst_new_frame: got valid=%b sum=%0d expected 1 12", bus16.valid_o, bus16.sum_o);
        end
    endtask

    initial begin
        bus.en_i = 1'b0; bus.clear_i = 1'b0; bus.data_i = '0; bus.ratio_i = '0; bus.shift_i = '0;
        bus16.en_i = 1'b0; bus16.clear_i = 1'b0; bus16.data_i = '0; bus16.ratio_i = '0; bus16.shift_i = '0;
        model_reset();
        test_reset();
        test_basic();
        test_ratio_one();
        test_gaps();
        test_saturation();
        test_clear();
        test_random();
        test_overflow16();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
